// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield.
package tug_pkg;

    typedef enum logic [1:0] {
        PLAY,
        WIN,
        OVER
    } state_t;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_RIGHT = 2'b01;
    localparam logic [1:0] WIN_LEFT  = 2'b10;

endpackage

// File: rtl/tug_playfield_edge_pulse.sv
// Rising-edge detector: one-cycle pulse when d_i is sampled high after being sampled low.
module edge_pulse (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic pulse_o
);

    logic d_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign pulse_o = d_i & ~d_q;

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: one lit position pulled left/right by button presses,
// round wins scored, hold period between rounds, match ends at WIN_SCORE.
//
//   state | meaning
//   PLAY  | one light lit, presses move it or win the round
//   WIN   | round just won, lights dark, waiting HOLD_CYCLES
//   OVER  | match finished, sticky until reset
module tug_playfield
    import tug_pkg::*;
#(
    parameter int NUM_LIGHTS  = 9,
    parameter int SCORE_W     = 3,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic [1:0]            round_winner,
    output logic [SCORE_W-1:0]    left_score,
    output logic [SCORE_W-1:0]    right_score,
    output logic                  game_over
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int C  = (NUM_LIGHTS - 1) / 2;
    localparam logic [NUM_LIGHTS-1:0] CENTRE    = {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << C;
    localparam logic [HW-1:0]         HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0]    SCORE_MAX = SCORE_W'(WIN_SCORE);

    logic press_l;
    logic press_r;

    state_t                  state_q;
    logic [NUM_LIGHTS-1:0]   lights_q;
    logic [1:0]              winner_q;
    logic [SCORE_W-1:0]      left_q;
    logic [SCORE_W-1:0]      right_q;
    logic [HW-1:0]           hold_q;
    logic                    over_q;

    edge_pulse u_edge_l (
        .clk     (clk),
        .reset   (reset),
        .d_i     (L),
        .pulse_o (press_l)
    );

    edge_pulse u_edge_r (
        .clk     (clk),
        .reset   (reset),
        .d_i     (R),
        .pulse_o (press_r)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= PLAY;
            lights_q <= CENTRE;
            winner_q <= WIN_NONE;
            left_q   <= '0;
            right_q  <= '0;
            hold_q   <= '0;
            over_q   <= 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    // Simultaneous presses cancel out.
                    if (press_l && !press_r) begin
                        if (lights_q[NUM_LIGHTS-1]) begin
                            lights_q <= '0;
                            winner_q <= WIN_LEFT;
                            left_q   <= left_q + SCORE_W'(1);
                            hold_q   <= '0;
                            state_q  <= WIN;
                        end else begin
                            lights_q <= lights_q << 1;
                        end
                    end else if (press_r && !press_l) begin
                        if (lights_q[0]) begin
                            lights_q <= '0;
                            winner_q <= WIN_RIGHT;
                            right_q  <= right_q + SCORE_W'(1);
                            hold_q   <= '0;
                            state_q  <= WIN;
                        end else begin
                            lights_q <= lights_q >> 1;
                        end
                    end
                end
                WIN: begin
                    if (hold_q == HOLD_LAST) begin
                        if (left_q == SCORE_MAX || right_q == SCORE_MAX) begin
                            state_q <= OVER;
                            over_q  <= 1'b1;
                        end else begin
                            state_q  <= PLAY;
                            lights_q <= CENTRE;
                            winner_q <= WIN_NONE;
                        end
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                OVER: begin
                end
                default: state_q <= PLAY;
            endcase
        end
    end

    assign lights       = lights_q;
    assign round_winner = winner_q;
    assign left_score   = left_q;
    assign right_score  = right_q;
    assign game_over    = over_q;

endmodule

// File: tb/tb_tug_playfield.sv
// Bench for tug_playfield: two instances (WIN_SCORE 7 and 2) against a position/score model.
module tb_tug_playfield;

    localparam int N    = 9;
    localparam int SW   = 3;
    localparam int HOLD = 4;
    localparam int CTR  = (N - 1) / 2;

    logic clk;
    logic reset;
    logic L;
    logic R;

    logic [N-1:0]  lights0, lights1;
    logic [1:0]    win0, win1;
    logic [SW-1:0] ls0, ls1, rs0, rs1;
    logic          go0, go1;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 0;

    tug_playfield #(.NUM_LIGHTS(N), .SCORE_W(SW), .WIN_SCORE(7), .HOLD_CYCLES(HOLD)) dut0 (
        .clk(clk), .reset(reset), .L(L), .R(R),
        .lights(lights0), .round_winner(win0), .left_score(ls0),
        .right_score(rs0), .game_over(go0)
    );

    tug_playfield #(.NUM_LIGHTS(N), .SCORE_W(SW), .WIN_SCORE(2), .HOLD_CYCLES(HOLD)) dut1 (
        .clk(clk), .reset(reset), .L(L), .R(R),
        .lights(lights1), .round_winner(win1), .left_score(ls1),
        .right_score(rs1), .game_over(go1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase 0 = playing, 1 = holding after a round, 2 = match over.
    int pos [2];
    int ph  [2];
    int hold[2];
    int mls [2];
    int mrs [2];
    int mwn [2];
    int ws  [2] = '{7, 2};
    bit mlq, mrq;

    task automatic model_win(int k, int who);
        ph[k]   = 1;
        hold[k] = HOLD;
        mwn[k]  = who;
        if (who == 2) mls[k]++;
        else          mrs[k]++;
    endtask

    always @(posedge clk or posedge reset) begin
        bit pl, pr;
        if (reset) begin
            mlq = 0;
            mrq = 0;
            for (int k = 0; k < 2; k++) begin
                pos[k] = CTR; ph[k] = 0; hold[k] = 0;
                mls[k] = 0; mrs[k] = 0; mwn[k] = 0;
            end
        end else begin
            pl  = L && !mlq;
            pr  = R && !mrq;
            mlq = L;
            mrq = R;
            for (int k = 0; k < 2; k++) begin
                if (ph[k] == 0) begin
                    if (pl && !pr) begin
                        if (pos[k] == N - 1) model_win(k, 2);
                        else pos[k]++;
                    end else if (pr && !pl) begin
                        if (pos[k] == 0) model_win(k, 1);
                        else pos[k]--;
                    end
                end else if (ph[k] == 1) begin
                    hold[k]--;
                    if (hold[k] == 0) begin
                        if (mls[k] == ws[k] || mrs[k] == ws[k]) begin
                            ph[k] = 2;
                        end else begin
                            ph[k] = 0; pos[k] = CTR; mwn[k] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_lights(int k);
        return (ph[k] == 0) ? (32'd1 << pos[k]) : 32'd0;
    endfunction

    task automatic compare_all();
        check("lights0", 32'(lights0), exp_lights(0));
        check("winner0", 32'(win0), 32'(mwn[0]));
        check("lscore0", 32'(ls0), 32'(mls[0]));
        check("rscore0", 32'(rs0), 32'(mrs[0]));
        check("over0",   32'(go0), 32'(ph[0] == 2));
        check("lights1", 32'(lights1), exp_lights(1));
        check("winner1", 32'(win1), 32'(mwn[1]));
        check("lscore1", 32'(ls1), 32'(mls[1]));
        check("rscore1", 32'(rs1), 32'(mrs[1]));
        check("over1",   32'(go1), 32'(ph[1] == 2));
    endtask

    always @(negedge clk) begin
        if (run_cmp && !reset) compare_all();
    end

    task automatic reset_literals(string tag);
        check({tag, "_lights0"}, 32'(lights0), 32'(9'b000010000));
        check({tag, "_lights1"}, 32'(lights1), 32'(9'b000010000));
        check({tag, "_scores0"}, 32'({ls0, rs0}), 32'd0);
        check({tag, "_scores1"}, 32'({ls1, rs1}), 32'd0);
        check({tag, "_winner"},  32'({win0, win1}), 32'd0);
        check({tag, "_over"},    32'({go0, go1}), 32'd0);
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset pulse placed strictly between clock edges.
    task automatic do_reset(bit lit);
        L = 0;
        R = 0;
        @(negedge clk);
        #2 reset = 1;
        #1;
        if (lit) reset_literals("reset");
        else compare_all();
        #1 reset = 0;
        @(negedge clk);
    endtask

    task automatic press_l();
        L = 1; tick(1); L = 0; tick(1);
    endtask

    task automatic press_r();
        R = 1; tick(1); R = 0; tick(1);
    endtask

    initial begin
        int bias, pl_pct, pr_pct;
        reset = 0;
        L = 0;
        R = 0;
        do_reset(1);
        run_cmp = 1;

        // Holding L moves once; simultaneous rise changes nothing.
        L = 1; tick(3); L = 0; tick(1);
        check("hold_once", 32'(lights0), 32'(9'b000100000));
        L = 1; R = 1; tick(1); L = 0; R = 0; tick(1);
        check("both_press", 32'(lights0), 32'(9'b000100000));

        // Left pushes off the end, presses ignored while holding.
        do_reset(0);
        repeat (4) press_l();
        check("four_l", 32'(lights0), 32'(9'b100000000));
        press_l();
        check("win_lights", 32'(lights0), 32'd0);
        check("win_winner", 32'(win0), 32'(2'b10));
        check("win_lscore", 32'(ls0), 32'd1);
        R = 1; tick(1); R = 0; tick(2);
        check("back_centre", 32'(lights0), 32'(9'b000010000));
        check("back_winner", 32'(win0), 32'd0);
        check("win_rign", 32'(rs0), 32'd0);
        press_r();
        check("first_after", 32'(lights0), 32'(9'b000001000));

        // Two right round wins end the WIN_SCORE=2 match.
        do_reset(0);
        repeat (2) begin
            repeat (5) press_r();
            tick(3);
        end
        check("over_flag1", 32'(go1), 32'd1);
        check("over_lights1", 32'(lights1), 32'd0);
        check("over_rscore1", 32'(rs1), 32'd2);
        check("notover0", 32'(go0), 32'd0);
        check("rscore0", 32'(rs0), 32'd2);
        repeat (2) press_l();
        repeat (6) press_r();
        check("over_sticky", 32'({go1, lights1, ls1, rs1, win1}), 32'({1'b1, 9'd0, 3'd0, 3'd2, 2'b01}));

        // Asynchronous reset in the middle of a hold.
        do_reset(0);
        repeat (5) press_l();
        tick(1);
        #2 reset = 1;
        #1 reset_literals("midwin");
        #1 reset = 0;
        tick(1);
        press_l();
        check("resume", 32'(lights0), 32'(9'b000100000));

        // Randomised play in biased epochs with occasional mid-cycle resets.
        pl_pct = 35;
        pr_pct = 35;
        for (int c = 0; c < 5000; c++) begin
            if (c % 200 == 0) begin
                bias = $urandom_range(0, 2);
                pl_pct = (bias == 1) ? 55 : (bias == 2) ? 10 : 35;
                pr_pct = (bias == 2) ? 55 : (bias == 1) ? 10 : 35;
            end
            if ($urandom_range(0, 899) == 0) begin
                #2 reset = 1;
                #1 compare_all();
                #1 reset = 0;
            end
            L = ($urandom_range(0, 99) < pl_pct);
            R = ($urandom_range(0, 99) < pr_pct);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tug_playfield.md
# tug_playfield

Parametrised tug-of-war playfield: a row of `NUM_LIGHTS` lights with exactly one lit during play. Left and right button presses pull the lit position toward the pressing player. Pushing past the end light wins the round and bumps that player's score. After a hold period the next round starts from the centre, and the match ends when a score reaches `WIN_SCORE`. It replaces a chain of per-light cells plus separate victory logic with one block that drives the board LEDs and the score displays.

## Interface
- `NUM_LIGHTS`, 9: number of lights; odd, ≥3.
- `SCORE_W`, 3: score counter width; `WIN_SCORE` < 2^`SCORE_W`.
- `WIN_SCORE`, 7: round wins needed to end the match; ≥1.
- `HOLD_CYCLES`, 4: cycles spent in WIN before the next round; ≥1.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `L`  in  1  left button level, synchronous to `clk`.
- `R`  in  1  right button level, synchronous to `clk`.
- `lights`  out  `NUM_LIGHTS`  bit 0 = rightmost, bit `NUM_LIGHTS`-1 = leftmost.
- `round_winner`  out  2  00 none, 01 right, 10 left.
- `left_score`  out  `SCORE_W`  left round-win count.
- `right_score`  out  `SCORE_W`  right round-win count.
- `game_over`  out  1  match finished.

## Operation
- Press detection:
  - pressL = `L` & ~Lq, where Lq is `L` registered; same for R.
  - Holding a button counts once.
  - Lq/Rq reset to 0, so a button held through reset registers one press on the first cycle after reset.
- States: PLAY, WIN, OVER.
- PLAY:
  - `lights` is one-hot at position p; C = (`NUM_LIGHTS`-1)/2.
  - pressL alone: if p < `NUM_LIGHTS`-1 then p+1; else left wins the round.
  - pressR alone: if p > 0 then p-1; else right wins the round.
  - pressL and pressR in the same cycle: no change.
- Round win (single edge):
  - `lights` ← 0.
  - `round_winner` ← 10 (left) or 01 (right).
  - Winner's score +1.
  - Hold counter ← 0; state ← WIN.
- WIN:
  - All presses ignored; Lq/Rq keep tracking.
  - Counter increments each cycle.
  - After `HOLD_CYCLES` cycles in WIN: if either score == `WIN_SCORE`, go to OVER. Otherwise go to PLAY with `lights` = one-hot C and `round_winner` ← 00.
- OVER:
  - Sticky until reset.
  - `lights` = 0, `game_over` = 1, `round_winner` and scores hold.
  - Presses ignored.
- Scores never exceed `WIN_SCORE`; no wrap-around is possible given the parameter constraint.

## Timing
- All outputs are registered.
- Reset values: `lights` = one-hot C, `round_winner` = 00, both scores = 0, `game_over` = 0, state PLAY.
- Reset is asynchronous: outputs take reset values immediately, including mid-WIN or in OVER.
- Press latency: `lights`, score and `round_winner` update at the first rising edge at which `L`/`R` is sampled high after being sampled low.
- A round win is visible on all outputs at that same edge.
- WIN lasts exactly `HOLD_CYCLES` clock cycles.
- On WIN exit, the centre light and `round_winner` = 00 (or `game_over` = 1) appear at the same edge.
- A press edge arriving in the cycle the block returns to PLAY is acted on one cycle later; only edges sampled in PLAY count.

## Structure
- Package `tug_pkg` holds:
  - `state_t` enum {PLAY, WIN, OVER};
  - winner constants WIN_NONE = 2'b00, WIN_RIGHT = 2'b01, WIN_LEFT = 2'b10.
- Sub-module `edge_pulse`: rising-edge detector with async active-high reset, instantiated once each for `L` and `R`.
- Hold counter width is $clog2(`HOLD_CYCLES`+1).

## Test plan
- Reset with defaults → `lights` = 9'b000010000, scores 0/0, `round_winner` = 00, `game_over` = 0.
- `L` held high 3 cycles → exactly one move to 9'b000100000. Then `L` and `R` rise in the same cycle → `lights` unchanged.
- Five separate `L` presses from reset → fourth press gives 9'b100000000. Fifth press gives `lights` = 0, `round_winner` = 10, `left_score` = 1. Four cycles later `lights` = 9'b000010000 and `round_winner` = 00.
- `R` presses issued during WIN → `lights` stay 0 and `right_score` stays 0. The first press after return to PLAY moves the light to 9'b000001000.
- `WIN_SCORE` = 2: two right-player round wins → `right_score` = 2. After the hold, `game_over` = 1 and `lights` = 0. Further presses change nothing.
- Reset asserted mid-WIN, between clock edges → outputs return to reset values immediately, before the next edge. Play resumes normally after deassertion.
